// File: rtl/triangle_projection_scheduler_if.sv
// rtl/triangle_projection_scheduler_if.sv - projected-triangle output stream toward the rasterizer
interface triangle_projection_scheduler_if #(
  parameter int COORD_WIDTH = 32
);
  logic [9*COORD_WIDTH-1:0] out_tri;
  logic                     out_valid;
  logic                     out_ready;

  modport master (output out_tri, output out_valid, input out_ready);
  modport slave  (input out_tri, input out_valid, output out_ready);
endinterface

// File: rtl/triangle_projection_scheduler.sv
// rtl/triangle_projection_scheduler.sv - frame sequencer: mesh BRAM fetch, one-at-a-time projection, output FIFO
module triangle_projection_scheduler #(
  parameter int COORD_WIDTH    = 32,
  parameter int ADDR_WIDTH     = 12,
  parameter int READ_LATENCY   = 2,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic [ADDR_WIDTH:0]          num_tris,
  output logic [ADDR_WIDTH-1:0]        tri_addr,
  output logic                         tri_rd_en,
  input  logic [9*COORD_WIDTH-1:0]     tri_data,
  output logic                         proj_start,
  output logic [9*COORD_WIDTH-1:0]     proj_verts,
  input  logic                         proj_done,
  input  logic                         proj_valid,
  input  logic [9*COORD_WIDTH-1:0]     proj_result,
  triangle_projection_scheduler_if.master out_if,
  output logic                         busy,
  output logic                         frame_done,
  output logic [ADDR_WIDTH:0]          tris_drawn,
  output logic [ADDR_WIDTH:0]          tris_culled,
  output logic                         timeout_err
);
  localparam int TW = 9 * COORD_WIDTH;
  localparam int NW = ADDR_WIDTH + 1;
  localparam int LW = $clog2(READ_LATENCY + 1);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_RD, S_PROJECT, S_COMMIT, S_FINISH
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, tri_addr_q, tri_addr_d;
  logic [NW-1:0]         num_q, num_d, idx_q, idx_d, drawn_q, drawn_d, culled_q, culled_d;
  logic [LW-1:0]         lat_q, lat_d;
  logic [CW-1:0]         tmo_q, tmo_d;
  logic [TW-1:0]         verts_q, verts_d, res_q, res_d;
  logic                  done_q, done_d, valid_q, valid_d;
  logic                  rd_en_q, rd_en_d, busy_q, busy_d, fdone_q, fdone_d, terr_q, terr_d;
  logic [TW-1:0]         mem_q [FIFO_DEPTH];
  logic [TW-1:0]         mem_d [FIFO_DEPTH];
  logic [PW-1:0]         wp_q, wp_d, rp_q, rp_d;
  logic [FW-1:0]         cnt_q, cnt_d;
  logic                  ov_q, ov_d;
  logic                  push, pop;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    tri_addr_d = tri_addr_q;
    num_d      = num_q;
    idx_d      = idx_q;
    drawn_d    = drawn_q;
    culled_d   = culled_q;
    lat_d      = lat_q;
    tmo_d      = tmo_q;
    verts_d    = verts_q;
    res_d      = res_q;
    done_d     = done_q;
    valid_d    = valid_q;
    rd_en_d    = 1'b0;
    busy_d     = busy_q;
    fdone_d    = 1'b0;
    terr_d     = terr_q;
    push       = 1'b0;
    pop        = ov_q && out_if.out_ready;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d   = base_addr;
          num_d    = num_tris;
          idx_d    = '0;
          drawn_d  = '0;
          culled_d = '0;
          terr_d   = 1'b0;
          busy_d   = 1'b1;
          state_d  = (num_tris == '0) ? S_FINISH : S_FETCH;
        end
      end
      S_FETCH: begin
        // Only fetch when a slot is guaranteed free for the eventual push.
        if (cnt_q < FW'(FIFO_DEPTH)) begin
          rd_en_d    = 1'b1;
          tri_addr_d = base_q + idx_q[ADDR_WIDTH-1:0];
          lat_d      = '0;
          state_d    = S_WAIT_RD;
        end
      end
      S_WAIT_RD: begin
        if (lat_q == LW'(READ_LATENCY)) begin
          verts_d = tri_data;
          tmo_d   = '0;
          state_d = S_PROJECT;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      S_PROJECT: begin
        if (proj_done) begin
          done_d  = 1'b1;
          valid_d = proj_valid;
          res_d   = proj_result;
          state_d = S_COMMIT;
        end else if (tmo_q == CW'(TIMEOUT_CYCLES - 1)) begin
          done_d   = 1'b0;
          culled_d = culled_q + NW'(1);
          terr_d   = 1'b1;
          state_d  = S_COMMIT;
        end else begin
          tmo_d = tmo_q + CW'(1);
        end
      end
      S_COMMIT: begin
        if (done_q && valid_q) begin
          push    = 1'b1;
          drawn_d = drawn_q + NW'(1);
        end else if (done_q) begin
          culled_d = culled_q + NW'(1);
        end
        done_d  = 1'b0;
        idx_d   = idx_q + NW'(1);
        state_d = (idx_d == num_q) ? S_FINISH : S_FETCH;
      end
      S_FINISH: begin
        if (cnt_q == '0) begin
          fdone_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    if (push) begin
      mem_d[wp_q] = res_q;
      wp_d        = wp_q + PW'(1);
    end
    if (pop) begin
      rp_d = rp_q + PW'(1);
    end
    cnt_d = cnt_q + FW'(push) - FW'(pop);
    ov_d  = (cnt_d != '0);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      tri_addr_q <= '0;
      num_q      <= '0;
      idx_q      <= '0;
      drawn_q    <= '0;
      culled_q   <= '0;
      lat_q      <= '0;
      tmo_q      <= '0;
      verts_q    <= '0;
      res_q      <= '0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      fdone_q    <= 1'b0;
      terr_q     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      ov_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      tri_addr_q <= tri_addr_d;
      num_q      <= num_d;
      idx_q      <= idx_d;
      drawn_q    <= drawn_d;
      culled_q   <= culled_d;
      lat_q      <= lat_d;
      tmo_q      <= tmo_d;
      verts_q    <= verts_d;
      res_q      <= res_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
      fdone_q    <= fdone_d;
      terr_q     <= terr_d;
      mem_q      <= mem_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      cnt_q      <= cnt_d;
      ov_q       <= ov_d;
    end
  end

  assign tri_addr         = tri_addr_q;
  assign tri_rd_en        = rd_en_q;
  assign proj_start       = (state_q == S_PROJECT);
  assign proj_verts       = verts_q;
  assign out_if.out_tri   = mem_q[rp_q];
  assign out_if.out_valid = ov_q;
  assign busy             = busy_q;
  assign frame_done       = fdone_q;
  assign tris_drawn       = drawn_q;
  assign tris_culled      = culled_q;
  assign timeout_err      = terr_q;
endmodule

// File: tb/tb_triangle_projection_scheduler.sv
// tb/tb_triangle_projection_scheduler.sv - randomized bench with mesh BRAM, engine and rasterizer models
module tb_triangle_projection_scheduler;
  localparam int CW = 32;
  localparam int AW = 12;
  localparam int RL = 2;
  localparam int FD = 4;
  localparam int TO = 16;
  localparam int TW = 9 * CW;

  logic          clk = 1'b0;
  logic          rst_n_in = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_tris = '0;
  logic [AW-1:0] tri_addr;
  logic          tri_rd_en;
  logic [TW-1:0] tri_data = '0;
  logic          proj_start;
  logic [TW-1:0] proj_verts;
  logic          proj_done = 1'b0;
  logic          proj_valid = 1'b0;
  logic [TW-1:0] proj_result = '0;
  logic          busy, frame_done, timeout_err;
  logic [AW:0]   tris_drawn, tris_culled;

  triangle_projection_scheduler_if #(.COORD_WIDTH(CW)) out_if();

  triangle_projection_scheduler #(
    .COORD_WIDTH(CW), .ADDR_WIDTH(AW), .READ_LATENCY(RL), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n_in), .start(start), .base_addr(base_addr), .num_tris(num_tris),
    .tri_addr(tri_addr), .tri_rd_en(tri_rd_en), .tri_data(tri_data),
    .proj_start(proj_start), .proj_verts(proj_verts), .proj_done(proj_done),
    .proj_valid(proj_valid), .proj_result(proj_result), .out_if(out_if),
    .busy(busy), .frame_done(frame_done), .tris_drawn(tris_drawn),
    .tris_culled(tris_culled), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic v; logic [AW-1:0] a;} rd_t;

  int            tests_run = 0;
  int            tests_failed = 0;
  int            cfg_delay [64];
  bit            cfg_valid [64];
  logic [31:0]   mesh_seed = 32'h1234_5678;
  bit            ready_hold = 1'b0;
  rd_t           rdq [$];
  rd_t           rd_h;
  logic [AW-1:0] rd_log [$];
  logic [TW-1:0] out_log [$];
  int            ps_len [$];
  int            fdone_cnt = 0;
  int            eng_cyc = 0;
  int            ei;
  logic [AW-1:0] exp_reads [$];
  logic [TW-1:0] exp_out [$];
  logic [AW:0]   exp_drawn, exp_culled;
  bit            exp_terr;

  function automatic logic [TW-1:0] mesh_word(input logic [AW-1:0] a);
    logic [TW-1:0] w;
    for (int k = 0; k < 9; k++) w[k*CW +: CW] = {mesh_seed[19:0] ^ 20'(k * 7919), a};
    return w;
  endfunction

  function automatic logic [TW-1:0] eng_fn(input logic [TW-1:0] v);
    return ~v ^ {9{32'hA5C3_0F1E}};
  endfunction

  function automatic logic [TW-1:0] junk();
    logic [TW-1:0] w;
    for (int k = 0; k < 9; k++) w[k*CW +: CW] = $urandom;
    return w;
  endfunction

  // Reference: every triangle is read in address order; only on-screen engine results reach the stream.
  function automatic void build_expect(input logic [AW-1:0] b, input int n);
    exp_reads.delete();
    exp_out.delete();
    exp_drawn = '0;
    exp_culled = '0;
    exp_terr = 1'b0;
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      a = b + AW'(i);
      exp_reads.push_back(a);
      if (cfg_delay[i] == 0) begin
        exp_culled++;
        exp_terr = 1'b1;
      end else if (cfg_valid[i]) begin
        exp_out.push_back(eng_fn(mesh_word(a)));
        exp_drawn++;
      end else begin
        exp_culled++;
      end
    end
  endfunction

  function automatic int diff_reads();
    int m;
    m = (rd_log.size() < exp_reads.size()) ? rd_log.size() : exp_reads.size();
    for (int i = 0; i < m; i++) if (rd_log[i] !== exp_reads[i]) return i;
    return (rd_log.size() == exp_reads.size()) ? -1 : m;
  endfunction

  function automatic int diff_out();
    int m;
    m = (out_log.size() < exp_out.size()) ? out_log.size() : exp_out.size();
    for (int i = 0; i < m; i++) if (out_log[i] !== exp_out[i]) return i;
    return (out_log.size() == exp_out.size()) ? -1 : m;
  endfunction

  // Environment models, all driven mid-cycle so the DUT samples settled values on posedge.
  always @(negedge clk) begin
    rdq.push_back({tri_rd_en, tri_addr});
    if (rdq.size() > RL) begin
      rd_h = rdq.pop_front();
      tri_data = rd_h.v ? mesh_word(rd_h.a) : junk();
    end
    if (tri_rd_en) rd_log.push_back(tri_addr);
    if (frame_done) fdone_cnt++;

    ei = rd_log.size() - 1;
    if (ei < 0) ei = 0;
    if (ei > 63) ei = 63;
    proj_done = 1'b0;
    proj_valid = 1'($urandom);
    proj_result = junk();
    if (proj_start && rst_n_in) begin
      eng_cyc++;
      if (cfg_delay[ei] != 0 && eng_cyc == cfg_delay[ei]) begin
        proj_done = 1'b1;
        proj_valid = cfg_valid[ei];
        proj_result = eng_fn(proj_verts);
      end
    end else begin
      if (eng_cyc != 0) ps_len.push_back(eng_cyc);
      eng_cyc = 0;
    end

    out_if.out_ready = ready_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    if (out_if.out_valid && out_if.out_ready) out_log.push_back(out_if.out_tri);
  end

  task automatic start_frame(input logic [AW-1:0] b, input int n);
    rd_log.delete();
    out_log.delete();
    ps_len.delete();
    fdone_cnt = 0;
    mesh_seed = $urandom;
    build_expect(b, n);
    @(negedge clk);
    start = 1'b1;
    base_addr = b;
    num_tris = n[AW:0];
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %0b want 0", busy); end
    tests_run++; if (out_if.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %0b want 0", out_if.out_valid); end
    tests_run++; if (tris_drawn !== '0) begin tests_failed++; $display("FAIL reset_drawn got %0d want 0", tris_drawn); end
    tests_run++; if (tris_culled !== '0) begin tests_failed++; $display("FAIL reset_culled got %0d want 0", tris_culled); end
    tests_run++; if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_done got %0b want 0", frame_done); end
    tests_run++; if (tri_rd_en !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_en got %0b want 0", tri_rd_en); end
    tests_run++; if (proj_start !== 1'b0) begin tests_failed++; $display("FAIL reset_proj_start got %0b want 0", proj_start); end
    tests_run++; if (timeout_err !== 1'b0) begin tests_failed++; $display("FAIL reset_timeout_err got %0b want 0", timeout_err); end
  endtask

  task automatic test_reset_mid_project();
    bit reached = 1'b0;
    ready_hold = 1'b1;
    cfg_delay[0] = 1; cfg_valid[0] = 1'b1;
    cfg_delay[1] = 0; cfg_valid[1] = 1'b1;
    cfg_delay[2] = 2; cfg_valid[2] = 1'b1;
    start_frame(12'h100, 3);
    for (int i = 0; i < 100 && !reached; i++) begin
      @(negedge clk);
      if (rd_log.size() == 2 && proj_start) reached = 1'b1;
    end
    repeat (2) @(negedge clk);
    tests_run++; if (!reached || out_if.out_valid !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_setup reached %0b out_valid %0b want 1 1", reached, out_if.out_valid); end
    rst_n_in = 1'b0;
    #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_busy got %0b want 0", busy); end
    tests_run++; if (out_if.out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_out_valid got %0b want 0", out_if.out_valid); end
    tests_run++; if (tris_drawn !== '0 || tris_culled !== '0) begin tests_failed++; $display("FAIL rst_mid_counters got %0d/%0d want 0/0", tris_drawn, tris_culled); end
    @(negedge clk);
    rst_n_in = 1'b1;
    repeat (40) @(negedge clk);
    tests_run++; if (fdone_cnt != 0) begin tests_failed++; $display("FAIL rst_mid_no_frame_done got %0d want 0", fdone_cnt); end
    tests_run++; if (rd_log.size() != 2 || busy !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_idle reads %0d busy %0b want 2 0", rd_log.size(), busy); end
    ready_hold = 1'b0;
  endtask

  task automatic test_basic();
    bit ok;
    for (int i = 0; i < 3; i++) begin cfg_delay[i] = $urandom_range(1, 5); cfg_valid[i] = 1'b1; end
    start_frame(12'h010, 3);
    wait_done(1000, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL basic_done got none want frame_done"); end
    tests_run++; if (diff_reads() != -1) begin tests_failed++; $display("FAIL basic_reads bad index %0d got %0d reads want %0d", diff_reads(), rd_log.size(), exp_reads.size()); end
    tests_run++; if (diff_out() != -1) begin tests_failed++; $display("FAIL basic_out bad index %0d got %0d tris want %0d", diff_out(), out_log.size(), exp_out.size()); end
    tests_run++; if (tris_drawn !== 13'd3 || tris_culled !== 13'd0) begin tests_failed++; $display("FAIL basic_counts got %0d/%0d want 3/0", tris_drawn, tris_culled); end
    tests_run++; if (fdone_cnt != 1) begin tests_failed++; $display("FAIL basic_one_frame_done got %0d want 1", fdone_cnt); end
  endtask

  task automatic test_cull();
    bit ok;
    for (int i = 0; i < 4; i++) begin cfg_delay[i] = $urandom_range(1, 4); cfg_valid[i] = (i % 2 == 0); end
    start_frame(12'($urandom), 4);
    wait_done(1000, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL cull_done got none want frame_done"); end
    tests_run++; if (diff_out() != -1) begin tests_failed++; $display("FAIL cull_out bad index %0d got %0d tris want %0d", diff_out(), out_log.size(), exp_out.size()); end
    tests_run++; if (tris_drawn !== 13'd2 || tris_culled !== 13'd2) begin tests_failed++; $display("FAIL cull_counts got %0d/%0d want 2/2", tris_drawn, tris_culled); end
  endtask

  task automatic test_backpressure();
    bit ok;
    ready_hold = 1'b1;
    for (int i = 0; i < 6; i++) begin cfg_delay[i] = $urandom_range(1, 3); cfg_valid[i] = 1'b1; end
    start_frame(12'($urandom), 6);
    repeat (150) @(negedge clk);
    tests_run++; if (rd_log.size() != FD) begin tests_failed++; $display("FAIL bp_stall_reads got %0d want %0d", rd_log.size(), FD); end
    tests_run++; if (busy !== 1'b1 || out_if.out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_stall_state busy %0b out_valid %0b want 1 1", busy, out_if.out_valid); end
    ready_hold = 1'b0;
    wait_done(1000, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL bp_done got none want frame_done"); end
    tests_run++; if (diff_reads() != -1) begin tests_failed++; $display("FAIL bp_reads bad index %0d got %0d reads want %0d", diff_reads(), rd_log.size(), exp_reads.size()); end
    tests_run++; if (diff_out() != -1) begin tests_failed++; $display("FAIL bp_out bad index %0d got %0d tris want %0d", diff_out(), out_log.size(), exp_out.size()); end
    tests_run++; if (tris_drawn !== 13'd6) begin tests_failed++; $display("FAIL bp_drawn got %0d want 6", tris_drawn); end
  endtask

  task automatic test_timeout();
    bit ok;
    cfg_delay[0] = $urandom_range(1, 4); cfg_valid[0] = 1'b1;
    cfg_delay[1] = 0;                    cfg_valid[1] = 1'b1;
    cfg_delay[2] = $urandom_range(1, 4); cfg_valid[2] = 1'b1;
    start_frame(12'($urandom), 3);
    wait_done(1000, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL tmo_done got none want frame_done"); end
    tests_run++; if (ps_len.size() < 2 || ps_len[1] != TO) begin tests_failed++; $display("FAIL tmo_abort_cycles got %0d want %0d", (ps_len.size() < 2) ? -1 : ps_len[1], TO); end
    tests_run++; if (timeout_err !== 1'b1) begin tests_failed++; $display("FAIL tmo_err got %0b want 1", timeout_err); end
    tests_run++; if (tris_culled !== 13'd1 || tris_drawn !== 13'd2) begin tests_failed++; $display("FAIL tmo_counts got %0d/%0d want 2/1", tris_drawn, tris_culled); end
    tests_run++; if (diff_reads() != -1) begin tests_failed++; $display("FAIL tmo_reads bad index %0d got %0d reads want %0d", diff_reads(), rd_log.size(), exp_reads.size()); end
    tests_run++; if (diff_out() != -1) begin tests_failed++; $display("FAIL tmo_out bad index %0d got %0d tris want %0d", diff_out(), out_log.size(), exp_out.size()); end
  endtask

  task automatic test_wrap();
    bit ok;
    for (int i = 0; i < 2; i++) begin cfg_delay[i] = $urandom_range(1, 4); cfg_valid[i] = 1'b1; end
    start_frame(12'hFFF, 2);
    tests_run++; if (timeout_err !== 1'b0) begin tests_failed++; $display("FAIL wrap_err_cleared got %0b want 0", timeout_err); end
    wait_done(1000, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL wrap_done got none want frame_done"); end
    tests_run++; if (rd_log.size() != 2 || rd_log[0] !== 12'hFFF || rd_log[1] !== 12'h000) begin tests_failed++; $display("FAIL wrap_reads got %0d reads first %h want fff 000", rd_log.size(), (rd_log.size() > 0) ? rd_log[0] : 12'h0); end
    tests_run++; if (diff_out() != -1) begin tests_failed++; $display("FAIL wrap_out bad index %0d got %0d tris want %0d", diff_out(), out_log.size(), exp_out.size()); end
    rd_log.delete();
    @(negedge clk);
    start = 1'b1; base_addr = 12'($urandom); num_tris = '0;
    @(negedge clk);
    start = 1'b0;
    tests_run++; if (frame_done !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL zero_cycle1 frame_done %0b busy %0b want 0 1", frame_done, busy); end
    @(negedge clk);
    tests_run++; if (frame_done !== 1'b1) begin tests_failed++; $display("FAIL zero_cycle2 frame_done got %0b want 1", frame_done); end
    repeat (3) @(negedge clk);
    tests_run++; if (rd_log.size() != 0 || busy !== 1'b0) begin tests_failed++; $display("FAIL zero_no_reads reads %0d busy %0b want 0 0", rd_log.size(), busy); end
  endtask

  task automatic test_random();
    bit ok;
    int n;
    logic [AW-1:0] b;
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, 12);
      b = 12'($urandom);
      for (int i = 0; i < n; i++) begin
        cfg_delay[i] = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
        cfg_valid[i] = 1'($urandom_range(0, 1));
      end
      start_frame(b, n);
      @(negedge clk);
      start = 1'b1; base_addr = ~b; num_tris = 13'(n + 5);
      @(negedge clk);
      start = 1'b0;
      wait_done(3000, ok);
      tests_run++; if (!ok) begin tests_failed++; $display("FAIL rand%0d_done got none want frame_done", f); end
      tests_run++; if (diff_reads() != -1) begin tests_failed++; $display("FAIL rand%0d_reads bad index %0d got %0d reads want %0d", f, diff_reads(), rd_log.size(), exp_reads.size()); end
      tests_run++; if (diff_out() != -1) begin tests_failed++; $display("FAIL rand%0d_out bad index %0d got %0d tris want %0d", f, diff_out(), out_log.size(), exp_out.size()); end
      tests_run++; if (tris_drawn !== exp_drawn || tris_culled !== exp_culled) begin tests_failed++; $display("FAIL rand%0d_counts got %0d/%0d want %0d/%0d", f, tris_drawn, tris_culled, exp_drawn, exp_culled); end
      tests_run++; if (timeout_err !== exp_terr || fdone_cnt != 1) begin tests_failed++; $display("FAIL rand%0d_flags err %0b frame_dones %0d want %0b 1", f, timeout_err, fdone_cnt, exp_terr); end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n_in = 1'b1;
    @(negedge clk);
    test_reset();
    test_reset_mid_project();
    test_basic();
    test_cull();
    test_backpressure();
    test_timeout();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got no completion want summary before 90000 cycles");
    $fatal(1, "watchdog");
  end
endmodule
